// File: rtl/booth_mul_pkg.sv
// Shared definitions for the radix-4 Booth iterative multiplier.
//   state_t       : controller states (IDLE, CALC, DONE)
//   digit_t       : 3-bit Booth digit codes (ZERO, P1, P2, M2, M1)
//   booth_classify: maps a 3-bit multiplier window to its digit code
//   booth_decode  : maps a 3-bit multiplier window to {neg, two, zero}
package booth_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    DIG_ZERO = 3'd0,
    DIG_P1   = 3'd1,
    DIG_P2   = 3'd2,
    DIG_M2   = 3'd3,
    DIG_M1   = 3'd4
  } digit_t;

  // Window is {b[2i+1], b[2i], b[2i-1]}. Note that 3'b111 is the "-0" digit:
  // it classifies as ZERO, but booth_decode still reports neg for it.
  function automatic digit_t booth_classify(input logic [2:0] win);
    case (win)
      3'b001, 3'b010: booth_classify = DIG_P1;
      3'b011:         booth_classify = DIG_P2;
      3'b100:         booth_classify = DIG_M2;
      3'b101, 3'b110: booth_classify = DIG_M1;
      default:        booth_classify = DIG_ZERO;
    endcase
  endfunction

  // Returns {neg, two, zero}. The -0 digit yields neg=1, zero=1; inverting 0
  // plus the injected +1 still sums to zero, so no special case is needed.
  function automatic logic [2:0] booth_decode(input logic [2:0] win);
    logic neg;
    logic two;
    logic zero;
    neg  = win[2];
    two  = (win == 3'b011) || (win == 3'b100);
    zero = (win == 3'b000) || (win == 3'b111);
    booth_decode = {neg, two, zero};
  endfunction

endpackage

// File: rtl/booth_r4_ppg.sv
// Combinational radix-4 Booth partial-product generator.
// Ports:
//   mulcand : WIDTH-bit multiplicand
//   digit   : 3-bit Booth window of the multiplier
//   sign    : 1 = multiplicand is two's complement, 0 = unsigned
//   pp      : WIDTH+2-bit partial product, already inverted for negative digits
//   neg     : 1 when pp is inverted; the +1 of the negation is added by the caller
module booth_r4_ppg
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] mulcand,
  input  logic [2:0]       digit,
  input  logic             sign,
  output logic [WIDTH+1:0] pp,
  output logic             neg
);

  logic [2:0]       dec;
  logic [WIDTH+1:0] m_ext;
  logic [WIDTH+1:0] mag;

  // WIDTH+2 bits hold 2M for both signed and unsigned multiplicands.
  always_comb begin
    dec   = booth_decode(digit);
    m_ext = {{2{sign & mulcand[WIDTH-1]}}, mulcand};
    if (dec[0]) begin
      mag = '0;
    end else if (dec[1]) begin
      mag = {m_ext[WIDTH:0], 1'b0};
    end else begin
      mag = m_ext;
    end
    neg = dec[2];
    pp  = neg ? ~mag : mag;
  end

endmodule

// File: rtl/booth_r4_iter_mul.sv
// Iterative radix-4 Booth multiplier, one Booth digit per clock.
// Optional feature macro: BOOTH_MUL_ACC_EN (adds acc_in, product = a*b + acc_in).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready only in IDLE)
//   mulcand, mulplier    : WIDTH-bit operands
//   sign                 : 1 = both operands signed, 0 = both unsigned
//   acc_in               : 2*WIDTH-bit addend (only with BOOTH_MUL_ACC_EN)
//   out_valid / out_ready: result handshake (out_valid only in DONE)
//   product              : 2*WIDTH-bit result, held until the next result
//   busy                 : high in CALC or DONE
module booth_r4_iter_mul
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mulcand,
  input  logic [WIDTH-1:0]   mulplier,
  input  logic               sign,
`ifdef BOOTH_MUL_ACC_EN
  input  logic [2*WIDTH-1:0] acc_in,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW     = 2 * WIDTH;
  localparam int DIGITS = WIDTH / 2 + 1;
  localparam int CW     = $clog2(DIGITS);
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q;
  logic             sign_q;
  logic [WIDTH+2:0] mr_q;
  logic [CW-1:0]    count_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    product_q;

  logic [WIDTH+1:0] pp;
  logic             neg;
  logic [PW-1:0]    pp_ext;
  logic [PW-1:0]    neg_ext;
  logic [CW:0]      shamt;
  logic [PW-1:0]    acc_sum;

  // The multiplier register carries an implicit 0 below bit 0, so the low
  // three bits are always the current Booth window; it shifts by two per digit.
  booth_r4_ppg #(.WIDTH(WIDTH)) u_ppg (
    .mulcand (mcand_q),
    .digit   (mr_q[2:0]),
    .sign    (sign_q),
    .pp      (pp),
    .neg     (neg)
  );

  // Digit i carries weight 4^i; the +1 of a negated partial product rides
  // along at the same weight. Bits beyond 2*WIDTH are dropped (mod 2^(2W)).
  always_comb begin
    pp_ext  = {{(PW-WIDTH-2){pp[WIDTH+1]}}, pp};
    neg_ext = {{(PW-1){1'b0}}, neg};
    shamt   = {count_q, 1'b0};
    acc_sum = acc_q + (pp_ext << shamt) + (neg_ext << shamt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake outputs are decoded purely from state so reset clears them at once.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (count_q == LAST) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are only sampled in IDLE, so input activity in CALC/DONE is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      sign_q    <= 1'b0;
      mr_q      <= '0;
      count_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q <= mulcand;
            sign_q  <= sign;
            mr_q    <= {{2{sign & mulplier[WIDTH-1]}}, mulplier, 1'b0};
            count_q <= '0;
`ifdef BOOTH_MUL_ACC_EN
            acc_q   <= acc_in;
`else
            acc_q   <= '0;
`endif
          end
        end
        CALC: begin
          acc_q   <= acc_sum;
          mr_q    <= mr_q >> 2;
          count_q <= count_q + 1'b1;
          if (count_q == LAST) product_q <= acc_sum;
        end
        default: begin
        end
      endcase
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_booth_r4_iter_mul.sv
// Self-checking bench for booth_r4_iter_mul: a 32-bit instance and an 8-bit
// instance share clock and reset. Expected products come from a plain
// widened-multiply model. Define BOOTH_MUL_ACC_EN to also exercise acc_in.
module tb_booth_r4_iter_mul;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] mulcand;
  logic [31:0] mulplier;
  logic        sign;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;

  logic        n_in_valid;
  logic        n_in_ready;
  logic [7:0]  n_mulcand;
  logic [7:0]  n_mulplier;
  logic        n_sign;
  logic        n_out_valid;
  logic        n_out_ready;
  logic [15:0] n_product;
  logic        n_busy;

`ifdef BOOTH_MUL_ACC_EN
  logic [63:0] acc_in;
  logic [15:0] n_acc_in;
`endif

  int checks = 0;
  int errors = 0;

  booth_r4_iter_mul #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mulcand   (mulcand),
    .mulplier  (mulplier),
    .sign      (sign),
`ifdef BOOTH_MUL_ACC_EN
    .acc_in    (acc_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  booth_r4_iter_mul #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (n_in_valid),
    .in_ready  (n_in_ready),
    .mulcand   (n_mulcand),
    .mulplier  (n_mulplier),
    .sign      (n_sign),
`ifdef BOOTH_MUL_ACC_EN
    .acc_in    (n_acc_in),
`endif
    .out_valid (n_out_valid),
    .out_ready (n_out_ready),
    .product   (n_product),
    .busy      (n_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: extend both operands to full width and multiply.
  function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input logic [63:0] acc);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb + acc;
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] ea;
    logic [15:0] eb;
    ea = s ? {{8{a[7]}}, a} : {8'b0, a};
    eb = s ? {{8{b[7]}}, b} : {8'b0, b};
    return ea * eb;
  endfunction

  // Drives one 32-bit operation and waits (bounded) for out_valid.
  // lat = number of edges after the accepting edge until out_valid is seen.
  task automatic do_mul32(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] acc, output logic [63:0] p, output int lat);
    @(negedge clk);
    mulcand  = a;
    mulplier = b;
    sign     = s;
`ifdef BOOTH_MUL_ACC_EN
    acc_in   = acc;
`endif
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mulcand  = $urandom;
    mulplier = $urandom;
    sign     = ~s;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    p = product;
  endtask

  task automatic do_mul8(input logic [7:0] a, input logic [7:0] b, input logic s,
                         output logic [15:0] p, output int lat);
    @(negedge clk);
    n_mulcand  = a;
    n_mulplier = b;
    n_sign     = s;
    n_in_valid = 1'b1;
    @(posedge clk);
    #1;
    n_in_valid = 1'b0;
    n_mulcand  = 8'($urandom);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (n_out_valid) break;
    end
    p = n_product;
    @(negedge clk);
    n_out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_out_ready = 1'b0;
  endtask

  task automatic finish32();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks += 5;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (product !== 64'h0) begin errors++; $display("[TB] FAIL reset_product: got %h expected 0", product); end
    if (n_product !== 16'h0) begin errors++; $display("[TB] FAIL reset_product8: got %h expected 0", n_product); end
    rst_n = 1'b1;
  endtask

  task automatic test_corners();
    logic [31:0] a_t [4];
    logic [31:0] b_t [4];
    logic        s_t [4];
    logic [63:0] e_t [4];
    logic [63:0] p;
    int lat;
    a_t[0] = 32'hFFFFFFFF; b_t[0] = 32'hFFFFFFFF; s_t[0] = 1'b1; e_t[0] = 64'h0000000000000001;
    a_t[1] = 32'hFFFFFFFF; b_t[1] = 32'hFFFFFFFF; s_t[1] = 1'b0; e_t[1] = 64'hFFFFFFFE00000001;
    a_t[2] = 32'h80000000; b_t[2] = 32'h80000000; s_t[2] = 1'b0; e_t[2] = 64'h4000000000000000;
    a_t[3] = 32'h80000000; b_t[3] = 32'h80000000; s_t[3] = 1'b1; e_t[3] = 64'h4000000000000000;
    for (int i = 0; i < 4; i++) begin
      do_mul32(a_t[i], b_t[i], s_t[i], 64'h0, p, lat);
      checks += 2;
      if (p !== e_t[i]) begin errors++; $display("[TB] FAIL corner_product[%0d]: got %h expected %h", i, p, e_t[i]); end
      if (lat !== 17) begin errors++; $display("[TB] FAIL corner_latency[%0d]: got %0d expected 17", i, lat); end
      finish32();
    end
  endtask

  task automatic test_narrow();
    logic [15:0] p;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    int lat;
    do_mul8(8'h80, 8'h7F, 1'b1, p, lat);
    checks += 2;
    if (p !== 16'hC080) begin errors++; $display("[TB] FAIL narrow_signed: got %h expected c080", p); end
    if (lat !== 5) begin errors++; $display("[TB] FAIL narrow_latency: got %0d expected 5", lat); end
    do_mul8(8'h80, 8'h7F, 1'b0, p, lat);
    checks++;
    if (p !== 16'h3F80) begin errors++; $display("[TB] FAIL narrow_unsigned: got %h expected 3f80", p); end
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom_range(0, 1));
      do_mul8(a, b, s, p, lat);
      checks++;
      if (p !== model8(a, b, s)) begin
        errors++;
        $display("[TB] FAIL narrow_random: %h*%h s=%b got %h expected %h", a, b, s, p, model8(a, b, s));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [5];
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] acc;
    logic [63:0] p;
    logic [63:0] exp;
    int lat;
    pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFFFFFF;
    pool[3] = 32'h80000000; pool[4] = 32'h7FFFFFFF;
    for (int i = 0; i < 30; i++) begin
      a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
      s = 1'($urandom_range(0, 1));
`ifdef BOOTH_MUL_ACC_EN
      acc = {$urandom, $urandom};
`else
      acc = 64'h0;
`endif
      exp = model32(a, b, s, acc);
      do_mul32(a, b, s, acc, p, lat);
      checks++;
      if (p !== exp || lat !== 17) begin
        errors++;
        $display("[TB] FAIL random: %h*%h s=%b got %h lat %0d expected %h lat 17", a, b, s, p, lat, exp);
      end
      finish32();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] p;
    logic [63:0] exp;
    int lat;
    int bad;
    exp = model32(32'h12345678, 32'h9ABCDEF0, 1'b1, 64'h0);
    do_mul32(32'h12345678, 32'h9ABCDEF0, 1'b1, 64'h0, p, lat);
    checks++;
    if (p !== exp) begin errors++; $display("[TB] FAIL bp_product: got %h expected %h", p, exp); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      mulcand  = $urandom;
      mulplier = $urandom;
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || product !== exp || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
    finish32();
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_valid: got %b expected 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready: got %b expected 1", in_ready); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_busy: got %b expected 0", busy); end
  endtask

  // in_valid held high across the result handshake must not start a new
  // operation on that edge; it is accepted on the following edge instead.
  task automatic test_back_to_back();
    logic [63:0] p;
    logic [63:0] exp;
    int lat;
    do_mul32(32'h00000007, 32'h00000009, 1'b0, 64'h0, p, lat);
    checks++;
    if (p !== 64'd63) begin errors++; $display("[TB] FAIL b2b_first: got %h expected 3f", p); end
    @(negedge clk);
    mulcand   = 32'hFFFFFFFE;
    mulplier  = 32'h00000003;
    sign      = 1'b1;
`ifdef BOOTH_MUL_ACC_EN
    acc_in    = 64'h0;
`endif
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_no_accept: got busy=%b in_ready=%b expected busy=0 in_ready=1", busy, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp = model32(32'hFFFFFFFE, 32'h00000003, 1'b1, 64'h0);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    checks++;
    if (product !== exp || lat !== 17) begin
      errors++;
      $display("[TB] FAIL b2b_second: got %h lat %0d expected %h lat 17", product, lat, exp);
    end
    finish32();
  endtask

  task automatic test_reset_mid();
    logic [63:0] p;
    int lat;
    int seen;
    @(negedge clk);
    mulcand  = 32'hDEADBEEF;
    mulplier = 32'h0BADF00D;
    sign     = 1'b0;
`ifdef BOOTH_MUL_ACC_EN
    acc_in   = 64'h0;
`endif
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b expected 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    if (product !== 64'h0) begin errors++; $display("[TB] FAIL midrst_product: got %h expected 0", product); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("[TB] FAIL midrst_no_pulse: got %0d valid cycles expected 0", seen); end
    do_mul32(32'd3, 32'd5, 1'b0, 64'h0, p, lat);
    checks++;
    if (p !== 64'hF) begin errors++; $display("[TB] FAIL midrst_after: got %h expected f", p); end
    finish32();
  endtask

`ifdef BOOTH_MUL_ACC_EN
  task automatic test_acc();
    logic [63:0] p;
    int lat;
    do_mul32(32'd3, 32'd5, 1'b0, 64'd7, p, lat);
    checks += 2;
    if (p !== 64'h16) begin errors++; $display("[TB] FAIL acc_small: got %h expected 16", p); end
    if (lat !== 17) begin errors++; $display("[TB] FAIL acc_latency: got %0d expected 17", lat); end
    finish32();
    do_mul32(32'hFFFFFFFF, 32'd1, 1'b1, 64'd1, p, lat);
    checks++;
    if (p !== 64'h0) begin errors++; $display("[TB] FAIL acc_wrap: got %h expected 0", p); end
    finish32();
  endtask
`endif

  initial begin
    in_valid    = 1'b0;
    mulcand     = '0;
    mulplier    = '0;
    sign        = 1'b0;
    out_ready   = 1'b0;
    n_in_valid  = 1'b0;
    n_mulcand   = '0;
    n_mulplier  = '0;
    n_sign      = 1'b0;
    n_out_ready = 1'b0;
`ifdef BOOTH_MUL_ACC_EN
    acc_in      = '0;
    n_acc_in    = '0;
`endif
    $display("[TB] starting");
    test_reset();
    test_corners();
    test_narrow();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef BOOTH_MUL_ACC_EN
    test_acc();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_r4_iter_mul.md
BOOTH_R4_ITER_MUL -- requirements
Module: booth_r4_iter_mul

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width in bits; even, >= 4.
REQ-002 SHALL have port: clk  input  1  rising-edge clock, single clock domain.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operand request.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: mulcand  input  WIDTH  multiplicand.
REQ-007 SHALL have port: mulplier  input  WIDTH  multiplier.
REQ-008 SHALL have port: sign  input  1  1 = both operands two's complement, 0 = both unsigned.
REQ-009 SHALL have port: out_valid  output  1  product available.
REQ-010 SHALL have port: out_ready  input  1  consumer takes product.
REQ-011 SHALL have port: product  output  2*WIDTH  result.
REQ-012 SHALL have port: busy  output  1  high in CALC or DONE.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE; operands and sign are captured on an edge with in_valid && in_ready, and the FSM moves to CALC.
REQ-015 SHALL extend the multiplier to WIDTH+2 bits: sign-extended if sign=1, zero-extended if sign=0. It SHALL process one radix-4 Booth digit per clock, LSB digit first, WIDTH/2+1 digits in total.
REQ-016 SHALL form each partial product from the multiplicand, extended per sign: 0, +M, +2M, -2M, -M, -0. Negation SHALL use invert-plus-one, with the +1 injected into the accumulator add.
REQ-017 SHALL enter DONE on the (WIDTH/2+1)th edge after the accepting edge, with out_valid = 1 from that edge (17 edges for WIDTH=32).
REQ-018 SHALL set product to mulcand*mulplier mod 2^(2*WIDTH): two's complement when sign=1, unsigned when sign=0.
REQ-019 SHALL hold product and out_valid stable in DONE while out_ready = 0.
REQ-020 SHALL return to IDLE on an edge with out_valid && out_ready; in_ready SHALL rise the cycle after; no accept in the same cycle as the result handshake.
REQ-021 SHALL ignore in_valid, mulcand, mulplier and sign while in CALC or DONE; captured operands SHALL be unaffected.
REQ-022 SHALL keep product at its last value in IDLE and CALC; product is meaningful only while out_valid = 1.

Reset
REQ-023 SHALL, on rst_n low, immediately force: state IDLE, in_ready 1 once state is IDLE, out_valid 0, busy 0, product 0, digit counter 0, accumulator 0.
REQ-024 SHALL, on reset asserted mid-CALC or in DONE, discard the operation; no out_valid pulse follows reset release.

Configuration
REQ-025 SHALL support macro BOOTH_MUL_ACC_EN. When defined: add port acc_in input 2*WIDTH, captured with the operands, used as the initial accumulator value; product = mulcand*mulplier + acc_in mod 2^(2*WIDTH), with the same latency. When undefined: no acc_in port, accumulator initialised to 0.

Structure
REQ-026 SHALL place in shared package booth_mul_pkg: FSM state enum; 3-bit Booth digit codes (ZERO, P1, P2, M2, M1); digit-decode function returning {neg, two, zero}.
REQ-027 SHALL instantiate sub-module booth_r4_ppg (parameter WIDTH), a combinational generator. Inputs: mulcand, 3-bit digit, sign. Outputs: WIDTH+2-bit partial product and neg bit. No other sub-modules.

Verification
REQ-028 SHALL cover (WIDTH=32): sign=1, 0xFFFFFFFF*0xFFFFFFFF -> product 0x0000000000000001, out_valid 17 edges after accept.
REQ-029 SHALL cover (WIDTH=32): sign=0, 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE00000001; sign=0 and sign=1, 0x80000000*0x80000000 -> 0x4000000000000000.
REQ-030 SHALL cover (WIDTH=8): sign=1, 0x80*0x7F -> 0xC080; sign=0 -> 0x3F80.
REQ-031 SHALL cover backpressure: out_ready low 5 cycles after out_valid -> product, out_valid stable, in_ready 0, in_valid pulses ignored; then out_ready=1 -> IDLE next edge.
REQ-032 SHALL cover reset mid-op: rst_n low 8 edges into CALC -> out_valid 0, busy 0, product 0 immediately; after release a new 3*5 (sign=0) -> 0xF.
REQ-033 SHALL cover, with BOOTH_MUL_ACC_EN: 3*5 + acc_in 7 -> 0x16; sign=1, 0xFFFFFFFF*1 + acc_in 1 -> 0.
